// File: rtl/stroke_gen.sv
// stroke_gen: scales camera blob positions into 640x480 screen space, debounces
// the pen and rasterises a Bresenham line between successive points.
module stroke_gen #(
  parameter int LOST_COUNT = 3,
  parameter int MIRROR_X   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic [9:0] cam_x,
  input  logic [9:0] cam_y,
  output logic [9:0] px_x,
  output logic [8:0] px_y,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       pen_down,
  output logic       busy,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  // Handshake: px_valid rises together with px_x/px_y and holds them until
  // px_valid & px_ready is seen on a rising edge; only reset drops it early.

  typedef enum logic [2:0] {S_IDLE, S_SCALE, S_SETUP, S_STEP, S_EMIT} state_t;
  state_t state;

  logic [9:0] p0x, p1x, curx, pend_x, pend_y;
  logic [8:0] p0y, p1y, cury;
  logic       pend_v, blob_r, single;
  logic [3:0] lost;
  logic signed [11:0] dx, dy, err;
  logic       x_neg, y_neg;

  logic [9:0]  src_x, src_y, scl_x, mir_x;
  logic [8:0]  scl_y;
  logic [12:0] mul_x, mul_y;
  logic        blob;

  // A waiting sample always takes priority over a fresh one in IDLE.
  assign src_x = pend_v ? pend_x : cam_x;
  assign src_y = pend_v ? pend_y : cam_y;
  assign mul_x = 13'(src_x) * 13'd5;
  assign mul_y = 13'(src_y) * 13'd5;
  assign scl_x = 10'(mul_x >> 3);
  assign scl_y = 9'(mul_y >> 3);
  assign mir_x = (MIRROR_X != 0) ? 10'd639 - scl_x : scl_x;
  assign blob  = (src_y <= 10'd767);

  logic signed [11:0] x0s, y0s, x1s, y1s, adx, ady, err_nxt;
  logic signed [12:0] e2;
  logic step_x, step_y;

  assign x0s = signed'(12'(p0x));
  assign y0s = signed'(12'(p0y));
  assign x1s = signed'(12'(p1x));
  assign y1s = signed'(12'(p1y));
  assign adx = (x1s >= x0s) ? x1s - x0s : x0s - x1s;
  assign ady = (y1s >= y0s) ? y1s - y0s : y0s - y1s;
  assign e2      = signed'({err, 1'b0});
  assign step_x  = e2 >= signed'({dy[11], dy});
  assign step_y  = e2 <= signed'({dx[11], dx});
  assign err_nxt = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);

  assign px_x      = curx;
  assign px_y      = cury;
  assign dbg_state = 3'(state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      p0x      <= '0;
      p0y      <= '0;
      p1x      <= '0;
      p1y      <= '0;
      curx     <= '0;
      cury     <= '0;
      pend_v   <= 1'b0;
      pend_x   <= '0;
      pend_y   <= '0;
      blob_r   <= 1'b0;
      single   <= 1'b0;
      lost     <= '0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
      x_neg    <= 1'b0;
      y_neg    <= 1'b0;
      px_valid <= 1'b0;
      pen_down <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (sample && state != S_IDLE) begin
        pend_v <= 1'b1;
        pend_x <= cam_x;
        pend_y <= cam_y;
        if (pend_v) overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pend_v || sample) begin
            state  <= S_SCALE;
            busy   <= 1'b1;
            p1x    <= mir_x;
            p1y    <= scl_y;
            blob_r <= blob;
            single <= !pen_down;
            if (blob) begin
              pen_down <= 1'b1;
              lost     <= '0;
            end else if (lost < 4'(LOST_COUNT)) begin
              lost <= lost + 4'd1;
              if (lost + 4'd1 == 4'(LOST_COUNT)) pen_down <= 1'b0;
            end
            // Consuming the pending slot frees it for a same-cycle arrival.
            if (pend_v) begin
              pend_v <= sample;
              pend_x <= cam_x;
              pend_y <= cam_y;
            end
          end
        end
        S_SCALE: begin
          if (blob_r) begin
            state <= S_SETUP;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_SETUP: begin
          p0x   <= p1x;
          p0y   <= p1y;
          dx    <= adx;
          dy    <= -ady;
          err   <= adx - ady;
          x_neg <= x1s < x0s;
          y_neg <= y1s < y0s;
          if (single) begin
            curx     <= p1x;
            cury     <= p1y;
            px_valid <= 1'b1;
            state    <= S_EMIT;
          end else if (p1x == p0x && p1y == p0y) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            curx  <= p0x;
            cury  <= p0y;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          err <= err_nxt;
          if (step_x) curx <= x_neg ? curx - 10'd1 : curx + 10'd1;
          if (step_y) cury <= y_neg ? cury - 9'd1 : cury + 9'd1;
          px_valid <= 1'b1;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            if (curx == p1x && cury == p1y) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_STEP;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stroke_gen.sv
// Bench for stroke_gen: vector table, latency/overrun/reset sequences and
// random samples checked against a point-list model of scaling, pen and lines.
`timescale 1ns/1ps
module tb_stroke_gen;
  localparam int LOST   = 3;
  localparam int MIRROR = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample = 1'b0;
  logic [9:0] cam_x = '0;
  logic [9:0] cam_y = '0;
  logic       px_ready = 1'b0;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic       px_valid, pen_down, busy, overrun;
  logic [2:0] dbg_state;

  stroke_gen #(.LOST_COUNT(LOST), .MIRROR_X(MIRROR)) dut (
    .clk(clk), .reset(reset), .sample(sample), .cam_x(cam_x), .cam_y(cam_y),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .px_ready(px_ready),
    .pen_down(pen_down), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  bit bp_mode = 1'b0;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  // behavioural model state
  int m_pen = 0, m_lost = 0, m_x0 = 0, m_y0 = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [18:0] pack(input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = 10'(x);
    yv = 9'(y);
    return {xv, yv};
  endfunction

  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int ddx, ddy, er, e, x, y, sxd, syd;
    ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sxd = (x0 < x1) ? 1 : -1;
    syd = (y0 < y1) ? 1 : -1;
    er = ddx + ddy;
    x = x0;
    y = y0;
    while (!(x == x1 && y == y1)) begin
      e = 2 * er;
      if (e >= ddy) begin er += ddy; x += sxd; end
      if (e <= ddx) begin er += ddx; y += syd; end
      exp_q.push_back(pack(x, y));
    end
  endtask

  task automatic model_sample(input int cx, input int cy);
    int sx, sy;
    sx = (cx * 5) / 8;
    sy = (cy * 5) / 8;
    if (MIRROR != 0) sx = 639 - sx;
    if (cy > 767) begin
      if (m_lost < LOST) m_lost++;
      if (m_lost == LOST) m_pen = 0;
    end else begin
      if (m_pen == 0) exp_q.push_back(pack(sx, sy));
      else model_line(m_x0, m_y0, sx, sy);
      m_pen = 1;
      m_lost = 0;
      m_x0 = sx;
      m_y0 = sy;
    end
  endtask

  // monitor: drives px_ready, records handshakes, checks hold-while-stalled
  logic       stall_prev = 1'b0;
  logic       rdy;
  logic [9:0] hold_x;
  logic [8:0] hold_y;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(px_valid && px_x == hold_x && px_y == hold_y)) begin
          failures++;
          $display("FAIL hold got v=%0d (%0d,%0d) exp v=1 (%0d,%0d)",
                   px_valid, px_x, px_y, hold_x, hold_y);
        end
      end
      if (overrun) ov_cnt++;
      rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      px_ready = rdy;
      if (px_valid && rdy) got_q.push_back({px_x, px_y});
      stall_prev = px_valid && !rdy;
      hold_x = px_x;
      hold_y = px_y;
    end
  end

  // driver tasks
  task automatic send(input int cx, input int cy);
    cam_x = 10'(cx);
    cam_y = 10'(cy);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 20000) begin
      if (busy || px_valid) quiet = 0;
      else quiet++;
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, quiet, 3);
  endtask

  // scoreboard compare
  task automatic cmp_pixels(input string name);
    int bad;
    check({name, "_count"}, got_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_pixel idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", name, bad,
               got_q[bad][18:9], got_q[bad][8:0], exp_q[bad][18:9], exp_q[bad][8:0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int cx; int cy; bit bp; int pen; int cnt; int lx; int ly;
  } vec_t;
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{512, 384, 1'b0, 1, 10, 320, 240};
    vecs[1]  = '{536, 416, 1'b1, 1, 20, 335, 260};
    vecs[2]  = '{512, 384, 1'b0, 1, 20, 320, 240};
    vecs[3]  = '{0, 1023, 1'b0, 1, 0, 0, 0};
    vecs[4]  = '{0, 1023, 1'b0, 1, 0, 0, 0};
    vecs[5]  = '{528, 384, 1'b1, 1, 10, 330, 240};
    vecs[6]  = '{0, 800, 1'b0, 1, 0, 0, 0};
    vecs[7]  = '{0, 800, 1'b0, 1, 0, 0, 0};
    vecs[8]  = '{0, 800, 1'b0, 0, 0, 0, 0};
    vecs[9]  = '{528, 384, 1'b0, 1, 1, 330, 240};
    vecs[10] = '{528, 384, 1'b0, 1, 0, 0, 0};
    vecs[11] = '{1023, 767, 1'b1, 1, 309, 639, 479};
    vecs[12] = '{0, 0, 1'b0, 1, 639, 0, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({px_valid, pen_down, busy, overrun, px_x, px_y}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single point latency: sample in cycle 0, px_valid in cycle 3
    send(512, 384);
    model_sample(512, 384);
    check("c1_pen_down", int'(pen_down), 1);
    check("c1_busy", int'(busy), 1);
    check("c1_valid", int'(px_valid), 0);
    @(negedge clk);
    check("c2_valid", int'(px_valid), 0);
    @(negedge clk);
    check("c3_valid", int'(px_valid), 1);
    check("c3_xy", int'({px_x, px_y}), int'(pack(320, 240)));
    wait_idle("single");
    cmp_pixels("single");

    // line latency: first pixel in cycle 4
    send(528, 384);
    model_sample(528, 384);
    @(negedge clk);
    check("l2_valid", int'(px_valid), 0);
    @(negedge clk);
    check("l3_valid", int'(px_valid), 0);
    @(negedge clk);
    check("l4_valid", int'(px_valid), 1);
    check("l4_xy", int'({px_x, px_y}), int'(pack(321, 240)));
    wait_idle("hline");
    check("hline_busy", int'(busy), 0);
    cmp_pixels("hline");

    // vector table
    foreach (vecs[i]) begin
      bp_mode = vecs[i].bp;
      send(vecs[i].cx, vecs[i].cy);
      model_sample(vecs[i].cx, vecs[i].cy);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pen", i), int'(pen_down), vecs[i].pen);
      check($sformatf("vec%0d_cnt", i), got_q.size(), vecs[i].cnt);
      if (vecs[i].cnt > 0 && got_q.size() > 0)
        check($sformatf("vec%0d_last", i), int'(got_q[$]), int'(pack(vecs[i].lx, vecs[i].ly)));
      cmp_pixels($sformatf("vec%0d", i));
    end
    bp_mode = 1'b0;

    // overrun: two samples during a 100-pixel line, only the second survives
    ov_cnt = 0;
    send(160, 0);
    model_sample(160, 0);
    repeat (20) @(negedge clk);
    send(512, 384);
    repeat (20) @(negedge clk);
    send(528, 400);
    model_sample(528, 400);
    wait_idle("overrun");
    check("overrun_pulses", ov_cnt, 1);
    check("overrun_total", got_q.size(), 350);
    cmp_pixels("overrun");

    // reset in the middle of a line
    send(0, 0);
    for (int n = 0; n < 50 && !px_valid; n++) @(negedge clk);
    check("midline_valid", int'(px_valid), 1);
    reset = 1'b0;
    #1;
    check("midline_reset_outputs", int'({px_valid, pen_down, busy, overrun, px_x, px_y}), 0);
    @(negedge clk);
    reset = 1'b1;
    got_q.delete();
    exp_q.delete();
    m_pen = 0; m_lost = 0; m_x0 = 0; m_y0 = 0;
    @(negedge clk);
    send(512, 384);
    model_sample(512, 384);
    wait_idle("post_reset");
    check("post_reset_cnt", got_q.size(), 1);
    cmp_pixels("post_reset");

    // random samples against the model
    for (int r = 0; r < 20; r++) begin
      int cx, cy;
      cx = $urandom_range(0, 1023);
      cy = $urandom_range(0, 1023);
      bp_mode = 1'($urandom_range(0, 1));
      send(cx, cy);
      model_sample(cx, cy);
      wait_idle($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_pen", r), int'(pen_down), m_pen);
      cmp_pixels($sformatf("rnd%0d", r));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stroke_gen.md
# stroke_gen

Converts raw camera blob coordinates (1024x768 space, y=1023 meaning no blob) into a stream of 640x480 screen pixels to paint. It sits between `camera` and `write_buffer`. Each new blob position is scaled, and the pen-up/pen-down state is debounced. A Bresenham line is then rasterised from the previous point to the new one, so fast strokes draw continuously rather than as dots. The block emits one pixel per valid/ready handshake.

## Interface
- `LOST_COUNT`, 3: consecutive no-blob samples required before the pen lifts (1..15).
- `MIRROR_X`, 0: if 1, screen x = 639 - scaled x.
- `clk` input 1: single clock, the vga clock domain.
- `reset` input 1: asynchronous, active-low (asserted when 0).
- `sample` input 1: one-cycle strobe; `cam_x`/`cam_y` are valid this cycle. Already synchronised to `clk`.
- `cam_x` input 10: camera x, 0..1023.
- `cam_y` input 10: camera y, 0..767 valid; any value >767 (incl. 1023) = no blob.
- `px_x` output 10: screen x of the offered pixel, 0..639.
- `px_y` output 9: screen y, 0..479.
- `px_valid` output 1: pixel offered.
- `px_ready` input 1: consumer accepts; handshake = `px_valid & px_ready` on a rising edge.
- `pen_down` output 1: stroke in progress.
- `busy` output 1: rasteriser not idle.
- `overrun` output 1: one-cycle pulse when a pending sample is overwritten.

## Operation
- Scaling, registered: sx = (cam_x*5)>>3, sy = (cam_y*5)>>3; 13-bit intermediates, truncated. 1023->639, 767->479. Apply MIRROR_X after scaling.
- Pen logic, evaluated per processed sample:
  - Valid sample with pen up: pen_down<=1, lost counter<=0, emit the single point P1, then set P0<=P1.
  - Valid sample with pen down: lost counter<=0, rasterise P0->P1, set P0<=P1.
  - No-blob sample: lost counter increments, saturating at LOST_COUNT. When it reaches LOST_COUNT, pen_down<=0. No pixels are emitted.
- Rasterisation emits the Bresenham pixels from P0 to P1, excluding P0 and including P1.
  - dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy; 12-bit signed arithmetic.
  - Per step: e2=2*err. If e2>=dy: err+=dy, x+=sx_dir. If e2<=dx: err+=dx, y+=sy_dir.
  - If P1==P0, nothing is emitted.
- States:
  - IDLE: waits for a sample or pending.
  - SCALE: registers scaled coordinates and applies pen logic.
  - SETUP: computes dx, dy, err and directions.
  - STEP: advances one Bresenham step.
  - EMIT: px_valid high, waits for ready. On handshake, go to IDLE if cur==P1, else STEP.
- Single-point case: SCALE -> SETUP -> EMIT with cur=P1.
- Pending buffer, one deep:
  - A `sample` that arrives while busy is stored in pending. This includes no-blob samples.
  - A second arrival overwrites the stored sample and pulses `overrun`.
  - Pending is consumed on the return to IDLE, one cycle later.
- A `sample` in the same cycle that the last handshake completes goes to pending. It is not lost.
- While px_valid=1, px_x/px_y are held stable until the handshake. px_valid never drops without a handshake, except on reset.

## Timing
- Reset values, applied asynchronously while reset=0:
  - All outputs 0: px_valid, pen_down, busy, overrun, px_x, px_y.
  - Lost counter 0, pending empty, P0=(0,0), state IDLE.
- Reset asserted mid-line: the line is aborted immediately and px_valid falls without a handshake. After release the block starts with pen up.
- Latency from `sample` (cycle 0) in IDLE to the first px_valid:
  - Single point: cycle 3 (cycle 1 SCALE, cycle 2 SETUP, cycle 3 EMIT).
  - Line: cycle 4 (one STEP precedes EMIT).
- Throughput with px_ready held high: one pixel every 2 cycles (STEP, EMIT).
- busy=1 from the cycle after `sample` until the cycle after the final handshake.
- pen_down changes in the SCALE cycle, i.e. cycle 1 after `sample`.

## Test plan
- Single point: pen up, px_ready=1, sample (512,384) -> px_valid at cycle 3 with (320,240), exactly one handshake; pen_down=1.
- Horizontal line: then sample (528,384) -> 10 pixels, x=321..330, y=240, then busy=0.
- Diagonal with backpressure: from (320,240), sample (536,416) for screen (335,260); px_ready toggled 1/0 randomly.
  - Required: 20 pixels ending at (335,260).
  - Each step changes x or y by at most 1 and y always changes.
  - Coordinates stay stable while ready=0.
- Pen debounce, LOST_COUNT=3, pen down at (320,240):
  - Two samples with y=1023, then sample (528,384) -> line drawn from (320,240).
  - Three samples with y=800 -> pen_down=0; next sample (528,384) -> single pixel (330,240).
- Overrun: during a 100-pixel line, issue 2 samples -> one `overrun` pulse; only the second sample is rasterised after the line ends.
- Reset mid-line: reset=0 while px_valid=1 -> px_valid=0 in the same cycle, all outputs 0. After release, a sample emits a single point.
